key_pio: RTL and testbench

- Parametrised Avalon-MM input PIO for push-buttons and switches; next generation of the single-bit key input port.
- Adds WIDTH channels, a 2-FF input synchroniser, a per-bit debounce filter, selectable edge capture with write-1-to-clear, and a maskable interrupt.
- Sits between board pins and the Nios II system interconnect; one instance per button or switch bank.

---
 rtl/key_pio_pkg.sv | 14 +
 rtl/key_pio_debounce.sv | 39 +++
 rtl/key_pio.sv | 100 ++++++++++
 tb/tb_key_pio.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pio_pkg.sv
// Shared constants for the key_pio input port: edge capture modes and register map.
package key_pio_pkg;

  localparam int EDGE_LEVEL   = 0;
  localparam int EDGE_RISING  = 1;
  localparam int EDGE_FALLING = 2;
  localparam int EDGE_ANY     = 3;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_pio_debounce.sv
// Single-bit debounce filter: a change on din is accepted only after it has been
// stable for DEBOUNCE_CYCLES clocks. DEBOUNCE_CYCLES = 0 passes din straight through.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_filter
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          deb;

    // Any return to the accepted level restarts the count, so glitches are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        deb <= 1'b0;
      end else if (din == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= din;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign dout = deb;
  end

endmodule

// File: rtl/key_pio.sv
// Avalon-MM input PIO for buttons/switches: synchronised, debounced inputs with
// sticky edge capture (write-1-to-clear) and a maskable interrupt.
module key_pio
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sync2[i]),
      .dout   (deb[i])
    );
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = deb & ~deb_d;
      EDGE_FALLING: edge_det = ~deb & deb_d;
      EDGE_ANY:     edge_det = deb ^ deb_d;
      default:      edge_det = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask    <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) irq_mask <= wdata;
      if (EDGE_TYPE == EDGE_LEVEL) edgecapture <= '0;
      else if (wr_en && address == ADDR_EDGE) edgecapture <= (edgecapture & ~wdata) | edge_det;
      else edgecapture <= edgecapture | edge_det;
    end
  end

  assign irq = (EDGE_TYPE == EDGE_LEVEL) ? |(deb & irq_mask) : |(edgecapture & irq_mask);

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = deb;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_key_pio.sv
// Scoreboard bench for key_pio: four instances (rising, falling, any, level) share
// pins and bus; reads push expectations, a monitor checks each read response.
module tb_key_pio;
  import key_pio_pkg::*;

  localparam int R = 0;
  localparam int F = 1;
  localparam int A = 2;
  localparam int L = 3;

  typedef struct {
    int          dut;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
    string       name;
  } entry_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_data [4];
  logic        irq_v   [4];

  entry_t sb[$];
  logic   rd_pending;
  int     tests_run;
  int     tests_failed;

  key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .irq(irq_v[R]), .readdata(rd_data[R]));

  key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_FALLING)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .irq(irq_v[F]), .readdata(rd_data[F]));

  key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_ANY)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .irq(irq_v[A]), .readdata(rd_data[A]));

  key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_LEVEL)) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .irq(irq_v[L]), .readdata(rd_data[L]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // A read issued before a rising edge returns its data after that edge.
  always @(posedge clk) rd_pending <= chipselect && write_n;

  always @(negedge clk) begin
    entry_t e;
    if (rd_pending === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output(e.name, rd_data[e.dut], e.exp_rd);
        if (e.chk_irq) check_output({e.name, "_irq"}, {31'd0, irq_v[e.dut]}, {31'd0, e.exp_irq});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_read(input int d, input logic [1:0] a, input logic [31:0] exp_rd,
                            input logic chk_irq, input logic exp_irq, input string nm);
    entry_t e;
    e.dut = d; e.exp_rd = exp_rd; e.chk_irq = chk_irq; e.exp_irq = exp_irq; e.name = nm;
    sb.push_back(e);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic apply_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rd_pending   = 1'b0;
    reset_n      = 1'b0;
    in_port      = 4'hF;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    address      = 2'd0;
    writedata    = '0;

    // Reset held with all pins high, then acquisition after 2+4 edges
    tick(1);
    apply_read(R, ADDR_DATA, 32'h0, 1'b1, 1'b0, "rst_data");
    apply_read(R, ADDR_EDGE, 32'h0, 1'b1, 1'b0, "rst_edge");
    tick(1);
    reset_n = 1'b1;
    tick(5);
    apply_read(R, ADDR_DATA, 32'h0, 1'b1, 1'b0, "acq_early");
    apply_read(R, ADDR_DATA, 32'hF, 1'b1, 1'b0, "acq_data");

    in_port = 4'h0;
    tick(8);
    apply_write(ADDR_EDGE, 32'hF);
    apply_write(ADDR_MASK, 32'h2);

    // Bit 1 rises: deb on edge 6, edgecapture and irq on edge 7
    in_port = 4'h2;
    tick(5);
    apply_read(R, ADDR_DATA, 32'h0, 1'b1, 1'b0, "deb_before");
    apply_read(R, ADDR_DATA, 32'h2, 1'b1, 1'b1, "deb_after");
    apply_read(R, ADDR_EDGE, 32'h2, 1'b1, 1'b1, "ec_bit1");

    // 3-cycle glitch on bit 2 must be filtered
    in_port = 4'h6;
    tick(3);
    in_port = 4'h2;
    tick(8);
    apply_read(R, ADDR_DATA, 32'h2, 1'b1, 1'b1, "pulse_data");
    apply_read(R, ADDR_EDGE, 32'h2, 1'b1, 1'b1, "pulse_ec");

    apply_write(ADDR_EDGE, 32'h2);
    apply_read(R, ADDR_EDGE, 32'h0, 1'b1, 1'b0, "clr_ec");

    // Clear lands on the same edge a new rising edge is captured
    in_port = 4'h0;
    tick(8);
    in_port = 4'h2;
    tick(6);
    apply_write(ADDR_EDGE, 32'h2);
    apply_read(R, ADDR_EDGE, 32'h2, 1'b1, 1'b1, "set_wins");
    apply_write(ADDR_EDGE, 32'h2);
    apply_read(R, ADDR_EDGE, 32'h0, 1'b1, 1'b0, "set_wins_clr");

    apply_write(ADDR_MASK, 32'h0);
    in_port = 4'h7;
    tick(8);
    apply_read(R, ADDR_EDGE, 32'h5, 1'b1, 1'b0, "mask_off");
    apply_write(ADDR_MASK, 32'h4);
    apply_read(R, ADDR_MASK, 32'h4, 1'b1, 1'b1, "mask_on");

    apply_write(ADDR_RSVD, 32'hF);
    apply_read(R, ADDR_RSVD, 32'h0, 1'b0, 1'b0, "rsvd_zero");
    apply_write(ADDR_DATA, 32'hF);
    apply_read(R, ADDR_DATA, 32'h7, 1'b0, 1'b0, "data_ro");

    // Edge mode differences on bit 0
    apply_write(ADDR_EDGE, 32'hF);
    in_port = 4'h6;
    tick(8);
    apply_read(F, ADDR_EDGE, 32'h1, 1'b0, 1'b0, "fall_on_fall");
    apply_read(A, ADDR_EDGE, 32'h1, 1'b0, 1'b0, "any_on_fall");
    apply_read(R, ADDR_EDGE, 32'h0, 1'b0, 1'b0, "rise_no_fall");
    apply_write(ADDR_EDGE, 32'hF);
    in_port = 4'h7;
    tick(8);
    apply_read(F, ADDR_EDGE, 32'h0, 1'b0, 1'b0, "fall_no_rise");
    apply_read(A, ADDR_EDGE, 32'h1, 1'b0, 1'b0, "any_on_rise");

    apply_write(ADDR_MASK, 32'h1);
    apply_read(L, ADDR_EDGE, 32'h0, 1'b1, 1'b1, "lvl_ec_zero");
    in_port = 4'h6;
    tick(8);
    apply_read(L, ADDR_DATA, 32'h6, 1'b1, 1'b0, "lvl_irq_low");

    // Reset while edgecapture=A and bits 0/2 are mid-debounce (count 2)
    in_port = 4'h0;
    tick(8);
    apply_write(ADDR_EDGE, 32'hF);
    in_port = 4'hA;
    tick(8);
    apply_read(R, ADDR_EDGE, 32'hA, 1'b0, 1'b0, "pre_rst_ec");
    in_port = 4'hF;
    tick(4);
    reset_n = 1'b0;
    apply_read(R, ADDR_DATA, 32'h0, 1'b1, 1'b0, "mid_rst_data");
    apply_read(R, ADDR_EDGE, 32'h0, 1'b1, 1'b0, "mid_rst_ec");
    reset_n = 1'b1;
    apply_read(R, ADDR_EDGE, 32'h0, 1'b1, 1'b0, "post_rst_ec");
    apply_read(R, ADDR_MASK, 32'h0, 1'b1, 1'b0, "post_rst_mask");
    apply_read(R, ADDR_DATA, 32'h0, 1'b1, 1'b0, "post_rst_data");
    tick(2);
    apply_read(R, ADDR_DATA, 32'h0, 1'b1, 1'b0, "reacq_early");
    apply_read(R, ADDR_DATA, 32'hF, 1'b1, 1'b0, "reacq_data");

    tick(2);
    check_output("sb_leftover", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
